cmp_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares a single registered 32-bit compare datapath among `NUM_REQ` requesters. Each requester submits an operand pair over a valid/ready channel. The block grants one requester at a time, latches its operands and computes unsigned less-than and equality. It returns the result, tagged with the requester index, on a single valid/ready response channel. It sits between branch/compare clients and the shared comparator resource in the interconnect test fabric.

---
 rtl/cmp_share_arb.sv | 161 ++++++++++++++++
 tb/tb_cmp_share_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_share_arb
//  Description : Round-robin arbiter that shares one registered unsigned
//                compare datapath among NUM_REQ valid/ready requesters and
//                returns tagged less/equal results on one response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        rsp_less,
  output logic                        rsp_equal,
  output logic [15:0]                 done_cnt,
  output logic                        busy
);

  localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [DATA_W-1:0]    op_a_q, op_a_d;
  logic [DATA_W-1:0]    op_b_q, op_b_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_less_q, rsp_less_d;
  logic                 rsp_equal_q, rsp_equal_d;
  logic [15:0]          done_cnt_q, done_cnt_d;

  logic                 w_grant_found;
  logic [c_IDX_W-1:0]   w_grant_idx;
  logic [c_IDX_W:0]     w_cand;
  logic [NUM_REQ-1:0]   w_req_ready;
  logic [DATA_W:0]      w_diff;

  // Round-robin search: first valid requester at or after last_grant+1, wrapping.
  // The extra bit on w_cand keeps last_grant+k from overflowing before the wrap.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, last_grant_q} + (c_IDX_W+1)'(k);
      if (w_cand >= (c_IDX_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (c_IDX_W+1)'(NUM_REQ);
      end
      if (!w_grant_found && req_valid[w_cand[c_IDX_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand[c_IDX_W-1:0];
      end
    end
  end

  // One-hot accept for the winner, only while idle; independent of rsp_ready.
  always_comb begin
    w_req_ready = '0;
    if (state_q == ST_IDLE && w_grant_found) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Shared comparator: a - b via two's complement, carry-out clear means a < b.
  assign w_diff = {1'b0, op_a_q} + {1'b0, ~op_b_q} + {{DATA_W{1'b0}}, 1'b1};

  // Next-state and datapath updates for the IDLE -> CMP -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    cur_id_d     = cur_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_less_d   = rsp_less_q;
    rsp_equal_d  = rsp_equal_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_grant_found) begin
          op_a_d       = req_a[w_grant_idx*DATA_W +: DATA_W];
          op_b_d       = req_b[w_grant_idx*DATA_W +: DATA_W];
          cur_id_d     = ID_W'(w_grant_idx);
          last_grant_d = w_grant_idx;
          state_d      = ST_CMP;
        end
      end
      ST_CMP: begin
        rsp_less_d  = ~w_diff[DATA_W];
        rsp_equal_d = (w_diff[DATA_W-1:0] == '0);
        rsp_id_d    = cur_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= c_IDX_W'(NUM_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      cur_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_less_q   <= 1'b0;
      rsp_equal_q  <= 1'b0;
      done_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      cur_id_q     <= cur_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_less_q   <= rsp_less_d;
      rsp_equal_q  <= rsp_equal_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_less  = rsp_less_q;
  assign rsp_equal = rsp_equal_q;
  assign done_cnt  = done_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_share_arb
//  Description : Self-checking bench for cmp_share_arb: cycle-level reference
//                model plus directed vectors with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_share_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*DW-1:0]   req_a;
  logic [N*DW-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic              rsp_less;
  logic              rsp_equal;
  logic [15:0]       done_cnt;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp    = 0;
  int rsp_ids[$];

  cmp_share_arb #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_less  (rsp_less),
    .rsp_equal (rsp_equal),
    .done_cnt  (done_cnt),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 waiting for a grant, 1 compare cycle, 2 response outstanding
  int          m_phase;
  int          m_last;
  int          m_id;
  logic [31:0] m_a, m_b;
  logic        m_rv, m_less, m_eq;
  int          m_rid;
  int          m_cnt;
  bit          m_known = 0;

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      logic [N-1:0] exp_rdy;
      int g;
      @(negedge ACLK);
      #3;
      if (m_known) begin
        exp_rdy = '0;
        if (m_phase == 0) begin
          g = pick();
          if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_id",    32'(rsp_id),    32'(m_rid));
        chk("rsp_less",  32'(rsp_less),  32'(m_less));
        chk("rsp_equal", 32'(rsp_equal), 32'(m_eq));
        chk("done_cnt",  32'(done_cnt),  32'(m_cnt));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        if (rsp_valid && rsp_ready && ARESETn) begin
          rsp_ids.push_back(int'(rsp_id));
          n_rsp++;
        end
      end
      // advance the model across the coming rising edge
      if (!ARESETn) begin
        m_phase = 0; m_last = N - 1; m_id = 0;
        m_rv = 0; m_rid = 0; m_less = 0; m_eq = 0; m_cnt = 0;
        m_known = 1;
      end else if (m_known) begin
        case (m_phase)
          0: begin
            g = pick();
            if (g >= 0) begin
              m_a = req_a[g*DW +: DW];
              m_b = req_b[g*DW +: DW];
              m_id = g; m_last = g; m_phase = 1;
            end
          end
          1: begin
            m_less = (m_a < m_b);
            m_eq   = (m_a == m_b);
            m_rid  = m_id;
            m_rv   = 1;
            m_phase = 2;
          end
          default: begin
            if (rsp_ready) begin
              m_rv = 0;
              m_cnt = (m_cnt + 1) % 65536;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // Raise one request, drop it after its grant, return in the response cycle.
  task automatic run_single(input int i, input logic [31:0] a, input logic [31:0] b);
    set_req(i, 1'b1, a, b);
    tick();
    req_valid[i] = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic        cl [4];
    logic        ce [4];
    int          snap;
    int          guard;

    ca[0] = 32'hFFFF_FFFF; cb[0] = 32'hFFFF_FFFF; cl[0] = 0; ce[0] = 1;
    ca[1] = 32'h0000_0000; cb[1] = 32'hFFFF_FFFF; cl[1] = 1; ce[1] = 0;
    ca[2] = 32'h8000_0000; cb[2] = 32'h7FFF_FFFF; cl[2] = 0; ce[2] = 0;
    ca[3] = 32'h0000_0000; cb[3] = 32'h0000_0000; cl[3] = 0; ce[3] = 1;

    ARESETn = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    ARESETn = 1'b1;
    repeat (3) tick();

    // reset release, idle
    chk("idle_busy",      32'(busy), 0);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    chk("idle_done_cnt",  32'(done_cnt), 0);
    chk("idle_req_ready", 32'(req_ready), 0);

    // single request from requester 2
    set_req(2, 1'b1, 32'd5, 32'd9);
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id",    32'(rsp_id), 2);
    chk("single_less",      32'(rsp_less), 1);
    chk("single_equal",     32'(rsp_equal), 0);
    tick();
    chk("single_done_cnt",  32'(done_cnt), 1);

    // operand corners on requester 0
    for (int i = 0; i < 4; i++) begin
      run_single(0, ca[i], cb[i]);
      chk("corner_less",  32'(rsp_less), 32'(cl[i]));
      chk("corner_equal", 32'(rsp_equal), 32'(ce[i]));
      tick();
    end
    chk("corner_done_cnt", 32'(done_cnt), 5);

    // backpressure: requester 1 held while requester 3 keeps asking
    rsp_ready = 1'b0;
    set_req(3, 1'b1, 32'd10, 32'd20);
    run_single(1, 32'd7, 32'd7);
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_id",    32'(rsp_id), 1);
      chk("bp_less",      32'(rsp_less), 0);
      chk("bp_equal",     32'(rsp_equal), 1);
      chk("bp_busy",      32'(busy), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("bp_after_busy",      32'(busy), 0);
    chk("bp_after_rsp_valid", 32'(rsp_valid), 0);
    chk("bp_after_done_cnt",  32'(done_cnt), 6);
    chk("bp_after_req_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0;
    tick();
    rsp_ready = 1'b1;
    tick();
    chk("bp_r3_done_cnt", 32'(done_cnt), 7);

    // reset in the middle of a transaction
    set_req(0, 1'b1, 32'd1, 32'd2);
    set_req(1, 1'b1, 32'd3, 32'd3);
    set_req(2, 1'b1, 32'hFFFF_0000, 32'h0000_FFFF);
    set_req(3, 1'b1, 32'h10, 32'h0F);
    tick();
    chk("mid_busy_before", 32'(busy), 1);
    ARESETn = 1'b0;
    req_valid = '0;
    snap = n_rsp;
    tick();
    chk("rst_busy",      32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id",    32'(rsp_id), 0);
    chk("rst_done_cnt",  32'(done_cnt), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    tick();
    ARESETn = 1'b1;
    tick();
    chk("rst_no_response", 32'(n_rsp), 32'(snap));

    // all requesters continuously valid
    rsp_ids.delete();
    req_valid = '1;
    #1;
    chk("stream_first_grant", 32'(req_ready), 32'b0001);
    guard = 0;
    while (rsp_ids.size() < 8 && guard < 80) begin
      tick();
      guard++;
    end
    req_valid = '0;
    chk("stream_count", 32'(rsp_ids.size() >= 8), 1);
    for (int i = 0; i < 8; i++) begin
      if (i < rsp_ids.size()) chk("stream_id", 32'(rsp_ids[i]), 32'(i % 4));
    end
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
